// File: rtl/piece_renderer_if.sv
// piece_renderer_if: request/status and VGA pixel-write bundle for piece_renderer
//   start, cell_x, cell_y, piece  : draw request (master -> slave)
//   busy, done                    : request status (slave -> master)
//   plot, vga_x, vga_y, vga_colour: pixel write strobe and data (slave -> master)
interface piece_renderer_if;
  logic       start;
  logic [2:0] cell_x;
  logic [2:0] cell_y;
  logic [1:0] piece;
  logic       busy;
  logic       done;
  logic       plot;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  modport master (
    output start, cell_x, cell_y, piece,
    input  busy, done, plot, vga_x, vga_y, vga_colour
  );
  modport slave (
    input  start, cell_x, cell_y, piece,
    output busy, done, plot, vga_x, vga_y, vga_colour
  );
endinterface

// File: rtl/piece_renderer.sv
// piece_renderer: paints one CELL_PX x CELL_PX board cell as a stream of VGA pixel writes
//   clk    : rising-edge clock
//   resetn : synchronous, active-low reset
//   bus    : piece_renderer_if.slave (request in, busy/done/plot/vga_* out, all registered)
//   Optional build macro PIECE_RENDERER_BORDER_EN: paints the top row and left column of
//   each cell in grid colour 3'b001.
module piece_renderer #(
  parameter int CELL_PX  = 4,
  parameter int BOARD_N  = 8,
  parameter int X_ORIGIN = 0,
  parameter int Y_ORIGIN = 0
) (
  input logic             clk,
  input logic             resetn,
  piece_renderer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, DRAW, FIN} state_t;
  localparam logic [3:0] LAST = 4'(CELL_PX - 1);
  state_t     state_q, state_d;
  logic [2:0] cx_q, cx_d, cy_q, cy_d;
  logic [1:0] pc_q, pc_d;
  logic [3:0] px_q, px_d, py_q, py_d;
  logic       busy_q, busy_d, done_q, done_d, plot_q, plot_d;
  logic [7:0] vx_q, vx_d;
  logic [6:0] vy_q, vy_d;
  logic [2:0] col_q, col_d;
  logic       in_ok, px_wrap, last_px;
  logic [3:0] px_n, py_n;
  function automatic logic [17:0] pix(input logic [2:0] cx, input logic [2:0] cy,
                                      input logic [1:0] pc, input logic [3:0] px,
                                      input logic [3:0] py);
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
    x = 8'(X_ORIGIN) + 8'(cx) * 8'(CELL_PX) + 8'(px);
    y = 7'(Y_ORIGIN) + 7'(cy) * 7'(CELL_PX) + 7'(py);
    c = pc == 2'b11 ? 3'b000 : pc[1] ? 3'b111 : 3'b010;
`ifdef PIECE_RENDERER_BORDER_EN
    if (px == 4'd0 || py == 4'd0) c = 3'b001;
`endif
    return {x, y, c};
  endfunction
  assign in_ok   = {1'b0, bus.cell_x} < 4'(BOARD_N) && {1'b0, bus.cell_y} < 4'(BOARD_N);
  assign px_wrap = px_q == LAST;
  assign last_px = px_wrap && py_q == LAST;
  assign px_n    = px_wrap ? 4'd0 : px_q + 4'd1;
  assign py_n    = px_wrap ? py_q + 4'd1 : py_q;
  // The first pixel is computed straight from the request inputs so it is on the
  // bus in the cycle right after acceptance. Inside DRAW, plot_q doubles as the
  // "cell is on the board" flag: an off-board request spends one silent cycle in
  // DRAW and then finishes.
  always_comb begin
    state_d = state_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    pc_d    = pc_q;
    px_d    = px_q;
    py_d    = py_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    plot_d  = 1'b0;
    vx_d    = vx_q;
    vy_d    = vy_q;
    col_d   = col_q;
    case (state_q)
      IDLE: if (bus.start) begin
        state_d = DRAW;
        cx_d    = bus.cell_x;
        cy_d    = bus.cell_y;
        pc_d    = bus.piece;
        px_d    = 4'd0;
        py_d    = 4'd0;
        busy_d  = 1'b1;
        plot_d  = in_ok;
        if (in_ok) {vx_d, vy_d, col_d} = pix(bus.cell_x, bus.cell_y, bus.piece, 4'd0, 4'd0);
      end
      DRAW: if (!plot_q || last_px) begin
        state_d = FIN;
        done_d  = 1'b1;
      end else begin
        px_d   = px_n;
        py_d   = py_n;
        plot_d = 1'b1;
        {vx_d, vy_d, col_d} = pix(cx_q, cy_q, pc_q, px_n, py_n);
      end
      FIN: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      cx_q    <= '0;
      cy_q    <= '0;
      pc_q    <= '0;
      px_q    <= '0;
      py_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      plot_q  <= 1'b0;
      vx_q    <= '0;
      vy_q    <= '0;
      col_q   <= 3'b010;
    end else begin
      state_q <= state_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      pc_q    <= pc_d;
      px_q    <= px_d;
      py_q    <= py_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      plot_q  <= plot_d;
      vx_q    <= vx_d;
      vy_q    <= vy_d;
      col_q   <= col_d;
    end
  end
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.plot       = plot_q;
  assign bus.vga_x      = vx_q;
  assign bus.vga_y      = vy_q;
  assign bus.vga_colour = col_q;
endmodule

// File: tb/tb_piece_renderer.sv
// tb_piece_renderer: scoreboard bench driving three differently configured renderers in parallel
module tb_piece_renderer;
  logic clk = 1'b0;
  logic resetn;
  logic start;
  logic [2:0] cx, cy;
  logic [1:0] pc;
  always #5 clk = ~clk;
  piece_renderer_if b0 ();
  piece_renderer_if b1 ();
  piece_renderer_if b2 ();
  assign {b0.start, b0.cell_x, b0.cell_y, b0.piece} = {start, cx, cy, pc};
  assign {b1.start, b1.cell_x, b1.cell_y, b1.piece} = {start, cx, cy, pc};
  assign {b2.start, b2.cell_x, b2.cell_y, b2.piece} = {start, cx, cy, pc};
  piece_renderer u0 (.clk(clk), .resetn(resetn), .bus(b0));
  piece_renderer #(.X_ORIGIN(240)) u1 (.clk(clk), .resetn(resetn), .bus(b1));
  piece_renderer #(.CELL_PX(2), .BOARD_N(4), .X_ORIGIN(10), .Y_ORIGIN(125)) u2 (.clk(clk), .resetn(resetn), .bus(b2));
  localparam int CP[3] = '{4, 4, 2};
  localparam int BN[3] = '{8, 8, 4};
  localparam int XO[3] = '{0, 240, 10};
  localparam int YO[3] = '{0, 0, 125};
  typedef struct {
    bit         dn;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
    longint     t;
  } ev_t;
  ev_t q[3][$];
  int errs = 0;
  int checks = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s at %0t: got=%0h want=%0h", name, $time, act, exp);
    end
  endtask
  function automatic logic [2:0] col(input logic [1:0] p, input int px, input int py);
    logic [2:0] c;
    c = p == 2'b11 ? 3'b000 : p == 2'b10 ? 3'b111 : 3'b010;
`ifdef PIECE_RENDERER_BORDER_EN
    if (px == 0 || py == 0) c = 3'b001;
`endif
    return c;
  endfunction
  // t0 is the negedge at which start was presented; pixel i shows at t0+10*(i+1)
  task automatic expect_req(input int d, input int x, input int y, input logic [1:0] p,
                            input longint t0, input longint cut);
    bit ok;
    int n;
    ev_t e;
    ok = x < BN[d] && y < BN[d];
    n = ok ? CP[d] * CP[d] : 0;
    for (int i = 0; i < n; i++) begin
      e.dn = 0;
      e.x = 8'((XO[d] + x * CP[d] + i % CP[d]) % 256);
      e.y = 7'((YO[d] + y * CP[d] + i / CP[d]) % 128);
      e.c = col(p, i % CP[d], i / CP[d]);
      e.t = t0 + 10 * (i + 1);
      if (e.t <= cut) q[d].push_back(e);
    end
    e.dn = 1;
    e.x = '0;
    e.y = '0;
    e.c = '0;
    e.t = t0 + 10 * (ok ? n + 1 : 2);
    if (e.t <= cut) q[d].push_back(e);
  endtask
  task automatic mon(input int d, input logic pl, input logic dn, input logic bz,
                     input logic [7:0] x, input logic [6:0] y, input logic [2:0] c);
    ev_t e;
    if (pl || dn) begin
      if (q[d].size() == 0) chk($sformatf("u%0d_unexpected_event", d), {pl, dn}, 2'b00);
      else begin
        e = q[d].pop_front();
        chk($sformatf("u%0d_kind", d), {pl, dn}, e.dn ? 2'b01 : 2'b10);
        chk($sformatf("u%0d_time", d), 64'($time), 64'(e.t));
        if (e.dn) chk($sformatf("u%0d_busy_at_done", d), bz, 1'b1);
        else chk($sformatf("u%0d_pixel_xyc", d), {x, y, c}, {e.x, e.y, e.c});
      end
    end
  endtask
  always @(negedge clk) begin
    mon(0, b0.plot, b0.done, b0.busy, b0.vga_x, b0.vga_y, b0.vga_colour);
    mon(1, b1.plot, b1.done, b1.busy, b1.vga_x, b1.vga_y, b1.vga_colour);
    mon(2, b2.plot, b2.done, b2.busy, b2.vga_x, b2.vga_y, b2.vga_colour);
  end
  task automatic check_idle(input string name);
    chk({name, "_u0"}, {b0.busy, b0.done, b0.plot, b0.vga_x, b0.vga_y, b0.vga_colour}, {3'b000, 8'd0, 7'd0, 3'b010});
    chk({name, "_u1"}, {b1.busy, b1.done, b1.plot, b1.vga_x, b1.vga_y, b1.vga_colour}, {3'b000, 8'd0, 7'd0, 3'b010});
    chk({name, "_u2"}, {b2.busy, b2.done, b2.plot, b2.vga_x, b2.vga_y, b2.vga_colour}, {3'b000, 8'd0, 7'd0, 3'b010});
  endtask
  // hold: cycles start stays high; pulse: stray start with cell (0,0) mid-draw;
  // rst5: reset asserted right after the fifth pixel of a 4x4 cell
  task automatic run(input logic [2:0] x, input logic [2:0] y, input logic [1:0] p,
                     input int hold, input bit pulse, input bit rst5);
    longint t0;
    int n, lat;
    bit ok;
    t0 = $time;
    cx = x;
    cy = y;
    pc = p;
    start = 1'b1;
    for (int d = 0; d < 3; d++) begin
      ok = int'(x) < BN[d] && int'(y) < BN[d];
      lat = ok ? CP[d] * CP[d] + 1 : 2;
      for (int k = 0; k * (lat + 1) < hold; k++)
        expect_req(d, int'(x), int'(y), p, t0 + 10 * k * (lat + 1), rst5 ? t0 + 50 : t0 + 100000);
    end
    repeat (hold) @(negedge clk);
    start = 1'b0;
    if (pulse) begin
      repeat (2) @(negedge clk);
      {cx, cy, pc, start} = {3'd0, 3'd0, 2'b00, 1'b1};
      @(negedge clk);
      {cx, cy, pc, start} = {x, y, p, 1'b0};
    end
    if (rst5) begin
      repeat (4) @(negedge clk);
      resetn = 1'b0;
      @(negedge clk);
      check_idle("reset_abort");
      resetn = 1'b1;
    end else begin
      n = 0;
      while ((b0.busy || b1.busy || b2.busy) && n < 400) begin
        @(negedge clk);
        n++;
      end
      chk("busy_timeout", n < 400, 1'b1);
    end
    repeat (2) @(negedge clk);
    for (int d = 0; d < 3; d++) chk($sformatf("u%0d_missing_events", d), q[d].size(), 0);
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    resetn = 1'b0;
    {start, cx, cy, pc} = '0;
    repeat (2) @(negedge clk);
    check_idle("reset_state");
    resetn = 1'b1;
    @(negedge clk);
    run(3'd2, 3'd3, 2'b11, 1, 0, 0);
    run(3'd7, 3'd1, 2'b10, 1, 0, 0);
    chk("hold_u0_last_pixel", {b0.plot, b0.vga_x, b0.vga_y, b0.vga_colour}, {1'b0, 8'd31, 7'd7, 3'b111});
    chk("hold_u1_x_wrap", {b1.plot, b1.vga_x, b1.vga_y, b1.vga_colour}, {1'b0, 8'd15, 7'd7, 3'b111});
    run(3'd0, 3'd0, 2'b10, 1, 0, 0);
    run(3'd1, 3'd2, 2'b01, 1, 0, 0);
    run(3'd5, 3'd0, 2'b00, 1, 0, 0);
    run(3'd2, 3'd5, 2'b11, 1, 0, 0);
    run(3'd2, 3'd3, 2'b11, 1, 1, 0);
    run(3'd1, 3'd1, 2'b10, 20, 0, 0);
    run(3'd6, 3'd7, 2'b11, 1, 0, 1);
    resetn = 1'b0;
    {start, cx, cy, pc} = {1'b1, 3'd1, 3'd1, 2'b11};
    @(negedge clk);
    resetn = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    check_idle("start_during_reset");
    for (int d = 0; d < 3; d++) chk($sformatf("u%0d_final_queue", d), q[d].size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/piece_renderer.md
PIECE_RENDERER -- requirements
Module: piece_renderer

Interface
REQ-001 SHALL have parameter CELL_PX, default 4, side of one board cell in pixels (2..16).
REQ-002 SHALL have parameter BOARD_N, default 8, cells per board side (1..8).
REQ-003 SHALL have parameter X_ORIGIN, default 0, pixel x of board top-left corner.
REQ-004 SHALL have parameter Y_ORIGIN, default 0, pixel y of board top-left corner.
REQ-005 SHALL have port clk, input, 1, rising-edge clock.
REQ-006 SHALL have port resetn, input, 1, reset: synchronous, active-low.
REQ-007 SHALL have port start, input, 1, request to draw one cell.
REQ-008 SHALL have port cell_x, input, 3, board column.
REQ-009 SHALL have port cell_y, input, 3, board row.
REQ-010 SHALL have port piece, input, 2, cell content: 00/01 empty, 10 white, 11 black.
REQ-011 SHALL have port busy, output, 1, high while a request is in progress.
REQ-012 SHALL have port done, output, 1, one-cycle completion pulse.
REQ-013 SHALL have port plot, output, 1, VGA write strobe; vga_* valid when high.
REQ-014 SHALL have port vga_x, output, 8, pixel x.
REQ-015 SHALL have port vga_y, output, 7, pixel y.
REQ-016 SHALL have port vga_colour, output, 3, pixel colour.

Function
REQ-017 SHALL implement states IDLE, DRAW, FIN; all outputs registered.
REQ-018 In IDLE, start=1 SHALL latch cell_x, cell_y, piece, clear pixel counters px=0, py=0, set busy=1 next cycle.
REQ-019 start SHALL be ignored while busy=1; latched inputs SHALL NOT change during a request.
REQ-020 If latched cell_x>=BOARD_N or cell_y>=BOARD_N, SHALL go directly to FIN with zero plot cycles.
REQ-021 Otherwise DRAW SHALL emit exactly CELL_PX*CELL_PX plot=1 cycles, one pixel per clock, first in the cycle after start is sampled, no gaps.
REQ-022 Scan order: px increments 0..CELL_PX-1 each cycle; on px wrap, px=0 and py increments; after px=py=CELL_PX-1 go to FIN.
REQ-023 vga_x SHALL equal X_ORIGIN + cell_x*CELL_PX + px, truncated to 8 bits; vga_y SHALL equal Y_ORIGIN + cell_y*CELL_PX + py, truncated to 7 bits.
REQ-024 Colour map: piece 11 -> 3'b000, 10 -> 3'b111, 00/01 -> 3'b010 (board green).
REQ-025 FIN SHALL assert done=1, plot=0 for exactly one cycle, then IDLE with busy=0.
REQ-026 busy SHALL be high from the cycle after acceptance through the FIN cycle inclusive.
REQ-027 start held high across FIN SHALL be accepted in the following IDLE cycle (back-to-back, one idle cycle between requests).
REQ-028 When plot=0, vga_x/vga_y/vga_colour SHALL hold their last values.

Reset
REQ-029 resetn=0 at a rising edge SHALL force IDLE, busy=0, done=0, plot=0, vga_x=0, vga_y=0, vga_colour=3'b010, counters 0.
REQ-030 Reset during DRAW SHALL abort the request; no done pulse SHALL be produced for it.
REQ-031 start sampled in the same cycle as resetn=0 SHALL be ignored.

Configuration
REQ-032 Macro PIECE_RENDERER_BORDER_EN: when defined, pixels with px==0 or py==0 SHALL use grid colour 3'b001 regardless of piece; other pixels per REQ-024.
REQ-033 When PIECE_RENDERER_BORDER_EN is undefined, all pixels SHALL use the REQ-024 colour; plot count and timing SHALL be identical in both builds.

Verification
REQ-034 Defaults, start with cell (2,3), piece 11 -> 16 plot cycles, x 8..11, y 12..15, colour 000, done one cycle after last plot.
REQ-035 Start pulsed during DRAW with cell (0,0) -> ignored; only original 16 pixels emitted, one done.
REQ-036 cell_x=7, CELL_PX=4, X_ORIGIN=240 -> vga_x 268..271 truncated to 12..15 (8-bit wrap).
REQ-037 cell_y=5 with BOARD_N=4, start -> zero plots, done=1 two cycles after start.
REQ-038 resetn=0 after 5th plot -> plot=0, busy=0, vga_colour=010 next cycle, no done pulse.
REQ-039 BORDER_EN build, piece 10 at (0,0) -> 7 pixels colour 001 (px=0 or py=0), 9 pixels colour 111.
